// File: rtl/ysyx_22050612_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050612_regfile_mp
// Brief    : Multi-port integer register file with hardwired-zero r0, optional
//            same-cycle write->read bypass and a per-register busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050612_regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NREAD      = 2,
    parameter int NWRITE     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NWRITE-1:0]            wen,
    input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
    input  logic [NWRITE*DATA_WIDTH-1:0] wdata,
    input  logic [NREAD*ADDR_WIDTH-1:0]  raddr,
    output logic [NREAD*DATA_WIDTH-1:0]  rdata,
    output logic [NREAD-1:0]             rbusy,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_rd
);

    localparam int c_NREGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_rf [c_NREGS];
    logic [c_NREGS-1:0]    r_busy;
    logic [c_NREGS-1:0]    w_busy_next;
    logic [NWRITE-1:0]     w_wen;
    logic [NWRITE-1:0]     w_fwd;
    logic                  w_issue;

    // Writes to r0 are dropped here so neither the array nor the scoreboard sees them
    always_comb begin
        w_wen = '0;
        w_fwd = '0;
        for (int k = 0; k < NWRITE; k++) begin
            w_wen[k] = wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0);
            w_fwd[k] = rst_n && w_wen[k];
        end
    end

    assign w_issue = issue_valid && (issue_rd != '0);

    always_comb begin
        w_busy_next = r_busy;
        for (int k = 0; k < NWRITE; k++) begin
            if (w_wen[k]) begin
                w_busy_next[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        // A new issue supersedes the completing write
        if (w_issue) begin
            w_busy_next[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_rf[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            // Later ports overwrite earlier ones, so the highest-numbered port wins
            for (int k = 0; k < NWRITE; k++) begin
                if (w_wen[k]) begin
                    r_rf[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            r_busy <= w_busy_next;
        end
    end

    for (genvar j = 0; j < NREAD; j++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] w_data;
        logic                  w_bsy;
        logic                  w_hit;

        assign w_ra = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_data = r_rf[w_ra];
            w_bsy  = r_busy[w_ra];
            w_hit  = 1'b0;
            if (BYPASS != 0) begin
                for (int k = 0; k < NWRITE; k++) begin
                    if (w_fwd[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == w_ra)) begin
                        w_data = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                        w_hit  = 1'b1;
                    end
                end
            end
            if (w_hit && !(w_issue && (issue_rd == w_ra))) begin
                w_bsy = 1'b0;
            end
            if (w_ra == '0) begin
                w_data = '0;
                w_bsy  = 1'b0;
            end
        end

        assign rdata[j*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign rbusy[j]                          = w_bsy;
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050612_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050612_regfile_mp
// Brief    : Directed self-checking bench driving a bypassing and a
//            non-bypassing register file from the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050612_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 64;

    logic            clk;
    logic            rst_n;
    logic [1:0]      wen;
    logic [2*AW-1:0] waddr;
    logic [2*DW-1:0] wdata;
    logic [2*AW-1:0] raddr;
    logic [2*DW-1:0] rdata_b;
    logic [2*DW-1:0] rdata_n;
    logic [1:0]      rbusy_b;
    logic [1:0]      rbusy_n;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;

    int checks;
    int errors;

    ysyx_22050612_regfile_mp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(2), .NWRITE(2), .BYPASS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .issue_valid(issue_valid), .issue_rd(issue_rd)
    );

    ysyx_22050612_regfile_mp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(2), .NWRITE(2), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen[port]              = 1'b1;
        waddr[port*AW +: AW]   = a;
        wdata[port*DW +: DW]   = d;
    endtask

    task automatic idle();
        wen         = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        wen    = '0;
        waddr  = '0;
        wdata  = '0;
        raddr  = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;

        // Reset pulse between edges clears everything without a clock edge
        raddr = {5'd3, 5'd7};
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rdata0", rdata_b[0 +: DW], 64'd0);
        chk("rst_rdata1", rdata_b[DW +: DW], 64'd0);
        chk("rst_rbusy", {62'd0, rbusy_b}, 64'd0);
        chk("rst_nb_rdata0", rdata_n[0 +: DW], 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic write: bypass sees it now, non-bypass the next cycle
        raddr[0 +: AW] = 5'd3;
        wr(0, 5'd3, 64'hDEAD_BEEF);
        #1;
        chk("wr_byp_same", rdata_b[0 +: DW], 64'hDEAD_BEEF);
        chk("wr_nb_same", rdata_n[0 +: DW], 64'd0);
        tick();
        idle();
        #1;
        chk("wr_nb_next", rdata_n[0 +: DW], 64'hDEAD_BEEF);
        chk("wr_byp_next", rdata_b[0 +: DW], 64'hDEAD_BEEF);

        // r0 stays zero and never becomes busy
        raddr = '0;
        wr(0, 5'd0, 64'h1234);
        wr(1, 5'd0, 64'h1234);
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        #1;
        chk("r0_byp_rdata0", rdata_b[0 +: DW], 64'd0);
        chk("r0_byp_rdata1", rdata_b[DW +: DW], 64'd0);
        tick();
        idle();
        #1;
        chk("r0_nb_rdata0", rdata_n[0 +: DW], 64'd0);
        chk("r0_nb_rdata1", rdata_n[DW +: DW], 64'd0);
        chk("r0_rbusy", {60'd0, rbusy_b, rbusy_n}, 64'd0);

        // Collision: port 1 wins
        raddr[AW +: AW] = 5'd5;
        wr(0, 5'd5, 64'hAAAA);
        wr(1, 5'd5, 64'hBBBB);
        #1;
        chk("coll_byp_same", rdata_b[DW +: DW], 64'hBBBB);
        tick();
        idle();
        #1;
        chk("coll_nb", rdata_n[DW +: DW], 64'hBBBB);
        chk("coll_byp", rdata_b[DW +: DW], 64'hBBBB);

        // Scoreboard on r7
        raddr[0 +: AW] = 5'd7;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        chk("sb_issue_same", {63'd0, rbusy_n[0]}, 64'd0);
        tick();
        idle();
        #1;
        chk("sb_busy_byp", {63'd0, rbusy_b[0]}, 64'd1);
        chk("sb_busy_nb", {63'd0, rbusy_n[0]}, 64'd1);
        wr(0, 5'd7, 64'h55);
        #1;
        chk("sb_wr_byp_busy", {63'd0, rbusy_b[0]}, 64'd0);
        chk("sb_wr_nb_busy", {63'd0, rbusy_n[0]}, 64'd1);
        chk("sb_wr_byp_data", rdata_b[0 +: DW], 64'h55);
        tick();
        idle();
        #1;
        chk("sb_clr_byp", {63'd0, rbusy_b[0]}, 64'd0);
        chk("sb_clr_nb", {63'd0, rbusy_n[0]}, 64'd0);
        chk("sb_clr_data", rdata_n[0 +: DW], 64'h55);
        wr(1, 5'd7, 64'h66);
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        idle();
        #1;
        chk("sb_setwin_byp", {63'd0, rbusy_b[0]}, 64'd1);
        chk("sb_setwin_nb", {63'd0, rbusy_n[0]}, 64'd1);
        chk("sb_setwin_data", rdata_n[0 +: DW], 64'h66);

        // Reset mid-operation with r9 busy and holding data
        raddr[AW +: AW] = 5'd9;
        wr(0, 5'd9, 64'h77);
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        idle();
        #1;
        chk("mid_pre_data", rdata_n[DW +: DW], 64'h77);
        chk("mid_pre_busy", {63'd0, rbusy_n[1]}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_data_b", rdata_b[DW +: DW], 64'd0);
        chk("mid_rst_data_n", rdata_n[DW +: DW], 64'd0);
        chk("mid_rst_busy", {60'd0, rbusy_b, rbusy_n}, 64'd0);
        chk("mid_rst_r7", rdata_n[0 +: DW], 64'd0);
        wr(1, 5'd9, 64'h99);
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        #1;
        chk("mid_rst_nofwd", rdata_b[DW +: DW], 64'd0);
        tick();
        chk("mid_rst_ignored", rdata_n[DW +: DW], 64'd0);
        #2 rst_n = 1'b1;
        tick();
        issue_valid = 1'b0;
        wen         = '0;
        #1;
        chk("mid_rel_data", rdata_n[DW +: DW], 64'h99);
        chk("mid_rel_busy", {62'd0, rbusy_n}, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
